grid_step_ctrl: RTL and testbench

GRID_STEP_CTRL -- requirements
Module: grid_step_ctrl

---
 rtl/grid_step_ctrl_if.sv | 25 ++
 rtl/grid_step_ctrl.sv | 116 +++++++++++
 tb/tb_grid_step_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_step_ctrl_if.sv
// Command/status bundle between a grid evolution controller and its sequencer.
// The master drives the commands. The slave (grid_step_ctrl) returns the grid controls.
interface grid_step_ctrl_if #(
  parameter int GEN_W = 16
);
  logic             clear;
  logic             load;
  logic             run;
  logic             step;
  logic             sel;
  logic             grid_we;
  logic [GEN_W-1:0] gen_count;
  logic             running;
  logic             halted;

  modport master (
    output clear, load, run, step,
    input  sel, grid_we, gen_count, running, halted
  );

  modport slave (
    input  clear, load, run, step,
    output sel, grid_we, gen_count, running, halted
  );
endinterface

// File: rtl/grid_step_ctrl.sv
// Sequencer for a cellular-automaton grid register: seed load, single step,
// timed free-run evolution and halt at a generation limit.
module grid_step_ctrl #(
  parameter int DIV     = 4,
  parameter int GEN_W   = 16,
  parameter int MAX_GEN = 2**GEN_W - 1
) (
  input  logic          clk,
  input  logic          reset,
  grid_step_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAUSE,
    S_RUN,
    S_EVOLVE,
    S_HALT
  } state_t;

  localparam int                 TIMER_W      = $clog2(DIV);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(DIV - 1);
  localparam logic [GEN_W-1:0]   GEN_LIMIT    = GEN_W'(MAX_GEN);

  state_t             state_q, state_d;
  logic               ret_run_q, ret_run_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [GEN_W-1:0]   gen_inc;

  assign gen_inc = gen_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ret_run_q <= 1'b0;
      timer_q   <= '0;
      gen_q     <= '0;
    end else begin
      state_q   <= state_d;
      ret_run_q <= ret_run_d;
      timer_q   <= timer_d;
      gen_q     <= gen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_run_d = ret_run_q;
    timer_d   = timer_q;
    gen_d     = gen_q;

    // clear and load pre-empt every state, including an in-flight EVOLVE.
    if (bus.clear) begin
      state_d = S_IDLE;
      timer_d = '0;
      gen_d   = '0;
    end else if (bus.load && (state_q != S_LOAD)) begin
      state_d = S_LOAD;
      gen_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_LOAD: begin
          state_d = S_PAUSE;
          gen_d   = '0;
        end
        S_PAUSE: begin
          if (bus.step) begin
            state_d   = S_EVOLVE;
            ret_run_d = 1'b0;
          end else if (bus.run) begin
            state_d = S_RUN;
            timer_d = TIMER_RELOAD;
          end
        end
        S_RUN: begin
          if (!bus.run) begin
            state_d = S_PAUSE;
          end else if (timer_q == '0) begin
            state_d   = S_EVOLVE;
            ret_run_d = 1'b1;
            timer_d   = TIMER_RELOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_EVOLVE: begin
          gen_d = gen_inc;
          if (gen_inc == GEN_LIMIT) begin
            state_d = S_HALT;
          end else begin
            state_d = ret_run_q ? S_RUN : S_PAUSE;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs depend only on registered state, never on the command inputs.
  assign bus.sel       = (state_q != S_IDLE) && (state_q != S_LOAD);
  assign bus.grid_we   = (state_q == S_LOAD) || (state_q == S_EVOLVE);
  assign bus.gen_count = gen_q;
  assign bus.running   = (state_q == S_RUN) || ((state_q == S_EVOLVE) && ret_run_q);
  assign bus.halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_grid_step_ctrl.sv
// Bench for grid_step_ctrl: vector table, multi-cycle scenarios and random
// stimulus checked against a behavioural model.
module tb_grid_step_ctrl;

  localparam int DIV     = 4;
  localparam int GEN_W   = 16;
  localparam int MAX_GEN = 3;

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_RUN    = 3;
  localparam int M_EVOLVE = 4;
  localparam int M_HALT   = 5;

  logic clk;
  logic reset;

  grid_step_ctrl_if #(.GEN_W(GEN_W)) bus ();

  grid_step_ctrl #(
    .DIV    (DIV),
    .GEN_W  (GEN_W),
    .MAX_GEN(MAX_GEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic clr;
    logic ld;
    logic stp;
    logic rn;
    logic e_sel;
    logic e_we;
    int   e_gen;
    logic e_running;
    logic e_halted;
  } vec_t;

  vec_t vecs [24];

  int n_checks;
  int n_fail;

  // Behavioural model: the named modes plus a count of completed RUN cycles.
  int m_mode;
  int m_runcyc;
  bit m_back;
  int m_gen;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int e_sel, input int e_we,
                            input int e_gen, input int e_running, input int e_halted);
    chk({tag, ".sel"},       int'(bus.sel),       e_sel);
    chk({tag, ".grid_we"},   int'(bus.grid_we),   e_we);
    chk({tag, ".gen_count"}, int'(bus.gen_count), e_gen);
    chk({tag, ".running"},   int'(bus.running),   e_running);
    chk({tag, ".halted"},    int'(bus.halted),    e_halted);
  endtask

  task automatic model_step();
    if (reset || bus.clear) begin
      m_mode = M_IDLE;
      m_gen  = 0;
    end else if (bus.load && (m_mode != M_LOAD)) begin
      m_mode = M_LOAD;
      m_gen  = 0;
    end else if (m_mode == M_LOAD) begin
      m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE) begin
      if (bus.step) begin
        m_mode = M_EVOLVE;
        m_back = 1'b0;
      end else if (bus.run) begin
        m_mode   = M_RUN;
        m_runcyc = 0;
      end
    end else if (m_mode == M_RUN) begin
      if (!bus.run) begin
        m_mode = M_PAUSE;
      end else if (m_runcyc + 1 == DIV) begin
        m_mode = M_EVOLVE;
        m_back = 1'b1;
      end else begin
        m_runcyc++;
      end
    end else if (m_mode == M_EVOLVE) begin
      m_gen++;
      if (m_gen >= MAX_GEN) begin
        m_mode = M_HALT;
      end else if (m_back) begin
        m_mode   = M_RUN;
        m_runcyc = 0;
      end else begin
        m_mode = M_PAUSE;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic set_in(input logic r, input logic c, input logic l,
                        input logic s, input logic n);
    reset     = r;
    bus.clear = c;
    bus.load  = l;
    bus.step  = s;
    bus.run   = n;
  endtask

  task automatic do_reset_load();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_mode   = M_IDLE;
    m_runcyc = 0;
    m_back   = 1'b0;
    m_gen    = 0;
    set_in(1, 0, 0, 0, 0);

    //            rst clr ld stp rn  sel we gen run hlt
    vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0};  // reset
    vecs[1]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};  // idle
    vecs[2]  = '{0, 0, 0, 1, 1,   0, 0, 0, 0, 0};  // idle ignores step/run
    vecs[3]  = '{0, 0, 1, 0, 0,   0, 1, 0, 0, 0};  // LOAD
    vecs[4]  = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0};  // PAUSE
    vecs[5]  = '{0, 0, 0, 1, 0,   1, 1, 0, 0, 0};  // EVOLVE
    vecs[6]  = '{0, 0, 0, 0, 0,   1, 0, 1, 0, 0};  // PAUSE gen1
    vecs[7]  = '{0, 0, 0, 1, 1,   1, 1, 1, 0, 0};  // step beats run
    vecs[8]  = '{0, 0, 0, 0, 1,   1, 0, 2, 0, 0};  // back to PAUSE
    vecs[9]  = '{0, 0, 0, 0, 1,   1, 0, 2, 1, 0};  // RUN
    vecs[10] = '{0, 0, 0, 0, 0,   1, 0, 2, 0, 0};  // run dropped
    vecs[11] = '{0, 0, 0, 1, 0,   1, 1, 2, 0, 0};  // EVOLVE
    vecs[12] = '{0, 0, 0, 0, 0,   1, 0, 3, 0, 1};  // HALT at limit
    vecs[13] = '{0, 0, 0, 1, 1,   1, 0, 3, 0, 1};  // HALT ignores step/run
    vecs[14] = '{0, 1, 1, 0, 0,   0, 0, 0, 0, 0};  // clear beats load
    vecs[15] = '{0, 0, 1, 0, 0,   0, 1, 0, 0, 0};  // LOAD
    vecs[16] = '{0, 0, 0, 1, 0,   1, 0, 0, 0, 0};  // LOAD lasts one cycle
    vecs[17] = '{0, 0, 0, 1, 0,   1, 1, 0, 0, 0};  // EVOLVE
    vecs[18] = '{0, 1, 0, 0, 0,   0, 0, 0, 0, 0};  // clear mid-EVOLVE
    vecs[19] = '{0, 0, 1, 0, 0,   0, 1, 0, 0, 0};  // LOAD
    vecs[20] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0};  // PAUSE
    vecs[21] = '{0, 0, 0, 1, 0,   1, 1, 0, 0, 0};  // EVOLVE
    vecs[22] = '{0, 0, 1, 0, 0,   0, 1, 0, 0, 0};  // load during EVOLVE
    vecs[23] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0};  // PAUSE, count zeroed

    for (int i = 0; i < 24; i++) begin
      set_in(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].stp, vecs[i].rn);
      tick();
      $display("vec %0d: sel=%0b we=%0b gen=%0d running=%0b halted=%0b", i,
               bus.sel, bus.grid_we, bus.gen_count, bus.running, bus.halted);
      check_outs($sformatf("vec%0d", i), int'(vecs[i].e_sel), int'(vecs[i].e_we),
                 vecs[i].e_gen, int'(vecs[i].e_running), int'(vecs[i].e_halted));
    end

    // Free-run to halt: pulses 4, 9 and 14 cycles after RUN entry.
    do_reset_load();
    bus.run = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("freerun c%0d.grid_we", c), int'(bus.grid_we),
          (c == 4 || c == 9 || c == 14) ? 1 : 0);
      chk($sformatf("freerun c%0d.gen_count", c), int'(bus.gen_count),
          (c >= 15) ? 3 : (c >= 10) ? 2 : (c >= 5) ? 1 : 0);
      chk($sformatf("freerun c%0d.halted", c), int'(bus.halted), (c >= 15) ? 1 : 0);
      chk($sformatf("freerun c%0d.running", c), int'(bus.running), (c < 15) ? 1 : 0);
      tick();
    end
    bus.run = 1'b0;
    $display("freerun: done, gen=%0d halted=%0b", bus.gen_count, bus.halted);

    // Pause mid-run, then restart with a full period.
    do_reset_load();
    bus.run = 1'b1;
    tick();
    tick();
    check_outs("midrun.run", 1, 0, 0, 1, 0);
    bus.run = 1'b0;
    tick();
    check_outs("midrun.pause", 1, 0, 0, 0, 0);
    bus.run = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rerun c%0d.grid_we", c), int'(bus.grid_we), (c == 4) ? 1 : 0);
      if (c < 4) tick();
    end
    bus.run = 1'b0;
    tick();
    $display("pause mid-run: done, gen=%0d", bus.gen_count);

    // Reset two cycles into RUN with one generation committed.
    do_reset_load();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    check_outs("rstrun.gen1", 1, 0, 1, 0, 0);
    bus.run = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_outs("rstrun.reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outs($sformatf("rstrun.idle%0d", c), 0, 0, 0, 0, 0);
    end
    bus.run = 1'b0;
    $display("reset mid-run: done");

    // Random stimulus against the model.
    set_in(1, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      bus.clear = ($urandom_range(0, 39) == 0);
      bus.load  = ($urandom_range(0, 11) == 0);
      bus.step  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) bus.run = !bus.run;
      tick();
      $display("rand %0d: in r%0b c%0b l%0b s%0b n%0b -> sel=%0b we=%0b gen=%0d running=%0b halted=%0b",
               i, reset, bus.clear, bus.load, bus.step, bus.run,
               bus.sel, bus.grid_we, bus.gen_count, bus.running, bus.halted);
      check_outs($sformatf("rand%0d", i),
                 (m_mode != M_IDLE && m_mode != M_LOAD) ? 1 : 0,
                 (m_mode == M_LOAD || m_mode == M_EVOLVE) ? 1 : 0,
                 m_gen,
                 (m_mode == M_RUN || (m_mode == M_EVOLVE && m_back)) ? 1 : 0,
                 (m_mode == M_HALT) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
